// File: rtl/scic_pkg.sv
// Shared types and I/O register map for the SCIC memory/MMIO controller.
package scic_pkg;

  // Access sequencer: one request is accepted in IDLE and executed in BUSY.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Word offsets of the I/O registers relative to IO_BASE.
  localparam int unsigned LED_OFS  = 0;
  localparam int unsigned SW_OFS   = 1;
  localparam int unsigned STAT_OFS = 2;
  localparam int unsigned MASK_OFS = 3;
  localparam int unsigned IO_REGS  = 4;

endpackage

// File: rtl/scic_debounce.sv
// One switch channel: 2-flop synchroniser followed by a stability counter.
// A change is accepted only after DEBOUNCE_CYC consecutive mismatching cycles.
module scic_debounce
#(
  parameter int unsigned DEBOUNCE_CYC = 16
)(
  input  logic clock,
  input  logic reset,
  input  logic sw_raw,
  output logic db,
  output logic chg
);

  localparam int unsigned    CW      = $clog2(DEBOUNCE_CYC) + 1;
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYC - 1);

  logic          sync1, sync2;
  logic [CW-1:0] cnt;

  // High in the cycle whose closing edge flips the debounced value.
  assign chg = (sync2 != db) && (cnt == CNT_MAX);

  // Bring the raw switch into the clock domain.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= sw_raw;
      sync2 <= sync1;
    end
  end

  // Count mismatching cycles; any agreement restarts the count.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      db  <= 1'b0;
    end else if (sync2 == db) begin
      cnt <= '0;
    end else if (chg) begin
      db  <= ~db;
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/scic_mmio_controller.sv
// CPU-facing controller: word RAM plus an I/O window with LEDs, debounced
// switches, latched edge status, interrupt mask and a level interrupt.
// Every access takes a fixed two cycles: accept in IDLE, execute in BUSY,
// then a one-cycle ready pulse carrying the read data.
module scic_mmio_controller
  import scic_pkg::*;
#(
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned RAM_DEPTH    = 1024,
  parameter int unsigned NUM_SW       = 4,
  parameter int unsigned NUM_LED      = 4,
  parameter int unsigned DEBOUNCE_CYC = 16,
  parameter int unsigned IO_BASE      = 'hFF00
)(
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_fromCPU,
  input  logic              we,
  input  logic              re,
  output logic [DATA_W-1:0] data_toCPU,
  output logic              ready,
  input  logic [NUM_SW-1:0] switches,
  output logic [NUM_LED-1:0] LEDs,
  output logic              irq
);

  localparam int unsigned RAM_AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

  state_t              state, state_nxt;
  logic                start, busy, wr_en;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                we_q, re_q;

  logic [ADDR_W-1:0]   io_off;
  logic                is_ram, is_io;
  logic                sel_led, sel_sw, sel_stat, sel_mask;
  logic [RAM_AW-1:0]   ram_idx;
  logic [DATA_W-1:0]   mem [RAM_DEPTH];
  logic [DATA_W-1:0]   reg_rd;

  logic [NUM_LED-1:0]  led_q;
  logic [NUM_SW-1:0]   sw_db, sw_chg, status, mask, stat_clr;

  // Upper write-data bits beyond the register widths are intentionally dropped.
  logic unused_wdata;
  assign unused_wdata = ^wdata_q;

  assign busy  = (state == BUSY);
  assign wr_en = busy && we_q;
  assign LEDs  = led_q;

  // Switch conditioning, one channel per switch.
  for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
    scic_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
      .clock  (clock),
      .reset  (reset),
      .sw_raw (switches[i]),
      .db     (sw_db[i]),
      .chg    (sw_chg[i])
    );
  end

  // Next state: a request is only taken in IDLE and never in the ready cycle.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    case (state)
      IDLE: if ((we || re) && !ready) begin
        state_nxt = BUSY;
        start     = 1'b1;
      end
      BUSY: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Capture the request so the CPU bus may change during BUSY.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
    end else if (start) begin
      addr_q  <= address;
      wdata_q <= data_fromCPU;
      we_q    <= we;
      re_q    <= re;
    end
  end

  // Address decode of the latched request.
  always_comb begin
    io_off   = addr_q - ADDR_W'(IO_BASE);
    is_ram   = addr_q < ADDR_W'(RAM_DEPTH);
    is_io    = (addr_q >= ADDR_W'(IO_BASE)) && (io_off < ADDR_W'(IO_REGS));
    sel_led  = is_io && (io_off == ADDR_W'(LED_OFS));
    sel_sw   = is_io && (io_off == ADDR_W'(SW_OFS));
    sel_stat = is_io && (io_off == ADDR_W'(STAT_OFS));
    sel_mask = is_io && (io_off == ADDR_W'(MASK_OFS));
    ram_idx  = addr_q[RAM_AW-1:0];
  end

  // Register read mux, zero-extended; unmapped addresses read as zero.
  always_comb begin
    reg_rd = '0;
    if (sel_led)       reg_rd[NUM_LED-1:0] = led_q;
    else if (sel_sw)   reg_rd[NUM_SW-1:0]  = sw_db;
    else if (sel_stat) reg_rd[NUM_SW-1:0]  = status;
    else if (sel_mask) reg_rd[NUM_SW-1:0]  = mask;
  end

  // RAM write port, committed on the BUSY edge.
  always_ff @(posedge clock) begin
    if (wr_en && is_ram) mem[ram_idx] <= wdata_q;
  end

  // Read data and completion pulse; a combined write+read returns zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data_toCPU <= '0;
      ready      <= 1'b0;
    end else begin
      ready <= busy;
      if (busy && re_q) begin
        if (we_q)        data_toCPU <= '0;
        else if (is_ram) data_toCPU <= mem[ram_idx];
        else             data_toCPU <= reg_rd;
      end
    end
  end

  // Writable I/O registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      led_q <= '0;
      mask  <= '0;
    end else begin
      if (wr_en && sel_led)  led_q <= wdata_q[NUM_LED-1:0];
      if (wr_en && sel_mask) mask  <= wdata_q[NUM_SW-1:0];
    end
  end

  assign stat_clr = (wr_en && sel_stat) ? wdata_q[NUM_SW-1:0] : '0;

  // Edge status: any debounced change sets; write-1 clears; set beats clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) status <= '0;
    else        status <= (status & ~stat_clr) | sw_chg;
  end

  // Level interrupt, one cycle behind status.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) irq <= 1'b0;
    else        irq <= |(status & mask);
  end

endmodule

// File: tb/tb_scic_mmio_controller.sv
// Directed bench for scic_mmio_controller with a read-data scoreboard.
module tb_scic_mmio_controller;

  localparam int          DC  = 16;
  localparam logic [15:0] IOB = 16'hFF00;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] address = '0;
  logic [31:0] data_fromCPU = '0;
  logic        we = 1'b0, re = 1'b0;
  logic [31:0] data_toCPU;
  logic        ready;
  logic [3:0]  switches = '0;
  logic [3:0]  LEDs;
  logic        irq;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  logic        irq_r;

  scic_mmio_controller #(
    .ADDR_W(16), .DATA_W(32), .RAM_DEPTH(1024), .NUM_SW(4), .NUM_LED(4),
    .DEBOUNCE_CYC(DC), .IO_BASE('hFF00)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .address      (address),
    .data_fromCPU (data_fromCPU),
    .we           (we),
    .re           (re),
    .data_toCPU   (data_toCPU),
    .ready        (ready),
    .switches     (switches),
    .LEDs         (LEDs),
    .irq          (irq)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Issue one access (caller sits just after a rising edge), wait for ready.
  task automatic bus(input string tag, input logic [15:0] a, input logic [31:0] d,
                     input logic w, input logic r, input logic [31:0] exp_rd,
                     output logic irq_rdy);
    int lat;
    bit got;
    address = a; data_fromCPU = d; we = w; re = r;
    if (r) exp_q.push_back(exp_rd);
    lat = 0; got = 0; irq_rdy = 1'bx;
    for (int i = 1; i <= 8 && !got; i++) begin
      @(posedge clock); #1;
      lat = i;
      if (ready) got = 1;
    end
    we = 1'b0; re = 1'b0;
    chk({tag, " latency"}, got ? lat : 99, 2);
    if (r) begin
      if (got) chk({tag, " rdata"}, data_toCPU, exp_q.pop_front());
      else     void'(exp_q.pop_front());
    end
    irq_rdy = irq;
    tick(1);
    chk({tag, " ready pulse"}, ready, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 reset = 1'b0;
    tick(3);
    chk("rst LEDs", LEDs, 4'h0);
    chk("rst ready", ready, 1'b0);
    chk("rst irq", irq, 1'b0);
    chk("rst data", data_toCPU, 32'h0);
    reset = 1'b1;
    tick(2);

    // RAM write/read.
    bus("wr5", 16'd5, 32'hDEADBEEF, 1, 0, 0, irq_r);
    bus("rd5", 16'd5, 32'h0, 0, 1, 32'hDEADBEEF, irq_r);

    // LED register.
    bus("wrled", IOB + 16'd0, 32'h0000000A, 1, 0, 0, irq_r);
    chk("LEDs", LEDs, 4'b1010);
    bus("rdled", IOB + 16'd0, 32'h0, 0, 1, 32'h0000000A, irq_r);

    // Mask keeps low bits only.
    bus("wrmask", IOB + 16'd3, 32'hFFFFFFF1, 1, 0, 0, irq_r);
    bus("rdmask", IOB + 16'd3, 32'h0, 0, 1, 32'h1, irq_r);

    // Bouncing switch must never be accepted (irq would reveal an edge).
    for (int i = 0; i < 42; i++) begin
      switches[0] = ((i / 3) % 2) == 0;
      tick(1);
      chk("bounce irq", irq, 1'b0);
    end
    switches[0] = 1'b1;
    tick(DC + 2);
    chk("db irq early", irq, 1'b0);
    tick(1);
    chk("db irq set", irq, 1'b1);
    bus("rdsw", IOB + 16'd1, 32'h0, 0, 1, 32'h1, irq_r);
    bus("rdstat", IOB + 16'd2, 32'h0, 0, 1, 32'h1, irq_r);

    // W1C clear; irq follows one cycle later.
    bus("clr", IOB + 16'd2, 32'h1, 1, 0, 0, irq_r);
    chk("irq at clr ready", irq_r, 1'b1);
    chk("irq after clr", irq, 1'b0);
    bus("rdstat0", IOB + 16'd2, 32'h0, 0, 1, 32'h0, irq_r);

    // Clear lands on the same edge as a new debounced change: set wins.
    switches[0] = 1'b0;
    tick(DC);
    bus("clr same", IOB + 16'd2, 32'h1, 1, 0, 0, irq_r);
    bus("rdstat same", IOB + 16'd2, 32'h0, 0, 1, 32'h1, irq_r);
    bus("rdsw0", IOB + 16'd1, 32'h0, 0, 1, 32'h0, irq_r);

    // Unmapped accesses and RAM boundaries.
    bus("rd8000", 16'h8000, 32'h0, 0, 1, 32'h0, irq_r);
    bus("wrio4", IOB + 16'd4, 32'h55, 1, 0, 0, irq_r);
    bus("rdio4", IOB + 16'd4, 32'h0, 0, 1, 32'h0, irq_r);
    bus("wr0", 16'd0, 32'h00001111, 1, 0, 0, irq_r);
    bus("wr1024", 16'd1024, 32'h00000BAD, 1, 0, 0, irq_r);
    bus("rd0", 16'd0, 32'h0, 0, 1, 32'h00001111, irq_r);
    bus("rd1024", 16'd1024, 32'h0, 0, 1, 32'h0, irq_r);
    bus("wr1023", 16'd1023, 32'h12345678, 1, 0, 0, irq_r);
    bus("rd1023", 16'd1023, 32'h0, 0, 1, 32'h12345678, irq_r);

    // Write and read together.
    bus("wrrd3", 16'd3, 32'h7, 1, 1, 32'h0, irq_r);
    bus("rd3", 16'd3, 32'h0, 0, 1, 32'h7, irq_r);

    // Reset in the middle of a read aborts it.
    address = 16'd5; re = 1'b1;
    tick(1);
    reset = 1'b0; re = 1'b0;
    #1;
    chk("abort ready", ready, 1'b0);
    chk("abort data", data_toCPU, 32'h0);
    chk("abort LEDs", LEDs, 4'h0);
    chk("abort irq", irq, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("abort no ready", ready, 1'b0);
    end
    reset = 1'b1;
    tick(2);
    chk("post-rst LEDs", LEDs, 4'h0);
    bus("rd5 again", 16'd5, 32'h0, 0, 1, 32'hDEADBEEF, irq_r);
    chk("scoreboard empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
